// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// State numbering is visible on state_o; encodings 13-15 are unused.
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StRtExec   = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiExec = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11,
      StJr       = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
   localparam logic [1:0] PCSRC_BTA   = 2'b01;
   localparam logic [1:0] PCSRC_JTA   = 2'b10;
   localparam logic [1:0] PCSRC_RS    = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUSRCB_REG  = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
   localparam logic [1:0] ALUSRCB_BOFS = 2'b11;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pcsrc;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Moore output decode for the multicycle controller; only the PC and IR
// enables look at live inputs (mem_ready, zero).
module mips_mc_outdec
   import mips_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.irwrite = mem_ready;
            ctrl.pc_en   = mem_ready;
            ctrl.alusrcb = ALUSRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_PLUS4;
         end
         StDecode: begin
            ctrl.alusrcb = ALUSRCB_BOFS;
            ctrl.aluop   = ALUOP_ADD;
         end
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         StMemRd: ctrl.iord = 1'b1;
         StMemWb: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StMemWr: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         StRtExec: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_REG;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         StAluWb: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StBranch: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_REG;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_BTA;
            // bne takes the branch when the compare is unequal
            ctrl.pc_en   = (op == OP_BNE) ? ~zero : zero;
         end
         StAddiExec: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         StAddiWb: ctrl.regwrite = 1'b1;
         StJump: begin
            ctrl.pcsrc = PCSRC_JTA;
            ctrl.pc_en = 1'b1;
         end
         StJr: begin
            ctrl.pcsrc = PCSRC_RS;
            ctrl.pc_en = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic, with
// write enables squashed combinationally while rst is high.
module mips_mc_ctrl
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [3:0] state_o
);

   state_e state_q;
   ctrl_t  ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         case (state_q)
            StFetch:  if (mem_ready) state_q <= StDecode;
            StDecode: begin
               case (op)
                  OP_LW, OP_SW:    state_q <= StMemAdr;
                  OP_RTYPE:        state_q <= (funct == FUNCT_JR) ? StJr : StRtExec;
                  OP_BEQ, OP_BNE:  state_q <= StBranch;
                  OP_ADDI:         state_q <= StAddiExec;
                  OP_J:            state_q <= StJump;
                  default:         state_q <= StFetch;
               endcase
            end
            StMemAdr:   state_q <= (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:    if (mem_ready) state_q <= StMemWb;
            StMemWr:    if (mem_ready) state_q <= StFetch;
            StRtExec:   state_q <= StAluWb;
            StAddiExec: state_q <= StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump, StJr: state_q <= StFetch;
            default:    state_q <= StFetch;
         endcase
      end
   end

   mips_mc_outdec u_outdec (
      .state     (state_q),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_en    = ctrl.pc_en    & ~rst;
   assign irwrite  = ctrl.irwrite  & ~rst;
   assign memwrite = ctrl.memwrite & ~rst;
   assign regwrite = ctrl.regwrite & ~rst;
   assign pcsrc    = ctrl.pcsrc;
   assign iord     = ctrl.iord;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign aluop    = ctrl.aluop;
   assign state_o  = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed per-cycle vector bench for mips_mc_ctrl plus a mid-stall reset sequence.
module tb_mips_mc_ctrl;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] pcsrc, alusrcb, aluop;
   logic [3:0] state_o;
   logic [13:0] outs;

   int checks = 0;
   int errors = 0;

   // {pc_en, pcsrc, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, aluop}
   localparam logic [13:0] O_FETCH_RDY  = 14'b1_00_0_1_0_0_0_0_0_01_00;
   localparam logic [13:0] O_FETCH_WAIT = 14'b0_00_0_0_0_0_0_0_0_01_00;
   localparam logic [13:0] O_DECODE     = 14'b0_00_0_0_0_0_0_0_0_11_00;
   localparam logic [13:0] O_MEMADR     = 14'b0_00_0_0_0_0_0_0_1_10_00;
   localparam logic [13:0] O_MEMRD      = 14'b0_00_1_0_0_0_0_0_0_00_00;
   localparam logic [13:0] O_MEMWB      = 14'b0_00_0_0_0_0_1_1_0_00_00;
   localparam logic [13:0] O_MEMWR      = 14'b0_00_1_0_1_0_0_0_0_00_00;
   localparam logic [13:0] O_RTEXEC     = 14'b0_00_0_0_0_0_0_0_1_00_10;
   localparam logic [13:0] O_ALUWB      = 14'b0_00_0_0_0_1_0_1_0_00_00;
   localparam logic [13:0] O_BR_TAKEN   = 14'b1_01_0_0_0_0_0_0_1_00_01;
   localparam logic [13:0] O_BR_NOT     = 14'b0_01_0_0_0_0_0_0_1_00_01;
   localparam logic [13:0] O_ADDIEXEC   = 14'b0_00_0_0_0_0_0_0_1_10_00;
   localparam logic [13:0] O_ADDIWB     = 14'b0_00_0_0_0_0_0_1_0_00_00;
   localparam logic [13:0] O_JUMP       = 14'b1_10_0_0_0_0_0_0_0_00_00;
   localparam logic [13:0] O_JR         = 14'b1_11_0_0_0_0_0_0_0_00_00;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        mem_ready;
      logic [3:0]  st;
      logic [13:0] outs;
      string       name;
   } vec_t;

   vec_t vecs[$];

   mips_mc_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_en     (pc_en),
      .pcsrc     (pcsrc),
      .iord      (iord),
      .irwrite   (irwrite),
      .memwrite  (memwrite),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .regwrite  (regwrite),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .aluop     (aluop),
      .state_o   (state_o)
   );

   assign outs = {pc_en, pcsrc, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, aluop};

   always #5 clk = ~clk;

   task automatic add_vec(input string name, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input logic mr, input state_e st,
                          input logic [13:0] exp_outs);
      vec_t v;
      v.op = o; v.funct = f; v.zero = z; v.mem_ready = mr;
      v.st = st; v.outs = exp_outs; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // add: FETCH, DECODE, RTEXEC, ALUWB
      add_vec("add",   OP_RTYPE, 6'b100000, 1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("add",   OP_RTYPE, 6'b100000, 1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("add",   OP_RTYPE, 6'b100000, 1'b0, 1'b1, StRtExec,   O_RTEXEC);
      add_vec("add",   OP_RTYPE, 6'b100000, 1'b0, 1'b1, StAluWb,    O_ALUWB);
      // lw with a fetch stall and three MEMRD stall cycles
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b0, StFetch,    O_FETCH_WAIT);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b1, StMemAdr,   O_MEMADR);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b0, StMemRd,    O_MEMRD);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b0, StMemRd,    O_MEMRD);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b0, StMemRd,    O_MEMRD);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b1, StMemRd,    O_MEMRD);
      add_vec("lw",    OP_LW,    6'd0,      1'b0, 1'b1, StMemWb,    O_MEMWB);
      // sw with one write stall
      add_vec("sw",    OP_SW,    6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("sw",    OP_SW,    6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("sw",    OP_SW,    6'd0,      1'b0, 1'b1, StMemAdr,   O_MEMADR);
      add_vec("sw",    OP_SW,    6'd0,      1'b0, 1'b0, StMemWr,    O_MEMWR);
      add_vec("sw",    OP_SW,    6'd0,      1'b0, 1'b1, StMemWr,    O_MEMWR);
      // branches: every op/zero combination
      add_vec("beq1",  OP_BEQ,   6'd0,      1'b1, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("beq1",  OP_BEQ,   6'd0,      1'b1, 1'b1, StDecode,   O_DECODE);
      add_vec("beq1",  OP_BEQ,   6'd0,      1'b1, 1'b1, StBranch,   O_BR_TAKEN);
      add_vec("bne1",  OP_BNE,   6'd0,      1'b1, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("bne1",  OP_BNE,   6'd0,      1'b1, 1'b1, StDecode,   O_DECODE);
      add_vec("bne1",  OP_BNE,   6'd0,      1'b1, 1'b1, StBranch,   O_BR_NOT);
      add_vec("bne0",  OP_BNE,   6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("bne0",  OP_BNE,   6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("bne0",  OP_BNE,   6'd0,      1'b0, 1'b1, StBranch,   O_BR_TAKEN);
      add_vec("beq0",  OP_BEQ,   6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("beq0",  OP_BEQ,   6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("beq0",  OP_BEQ,   6'd0,      1'b0, 1'b1, StBranch,   O_BR_NOT);
      // addi, j, jr
      add_vec("addi",  OP_ADDI,  6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("addi",  OP_ADDI,  6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("addi",  OP_ADDI,  6'd0,      1'b0, 1'b1, StAddiExec, O_ADDIEXEC);
      add_vec("addi",  OP_ADDI,  6'd0,      1'b0, 1'b1, StAddiWb,   O_ADDIWB);
      add_vec("j",     OP_J,     6'd0,      1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("j",     OP_J,     6'd0,      1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("j",     OP_J,     6'd0,      1'b0, 1'b1, StJump,     O_JUMP);
      add_vec("jr",    OP_RTYPE, FUNCT_JR,  1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("jr",    OP_RTYPE, FUNCT_JR,  1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("jr",    OP_RTYPE, FUNCT_JR,  1'b0, 1'b1, StJr,       O_JR);
      // illegal opcode falls straight back to FETCH
      add_vec("ill",   6'b111111, 6'd0,     1'b0, 1'b1, StFetch,    O_FETCH_RDY);
      add_vec("ill",   6'b111111, 6'd0,     1'b0, 1'b1, StDecode,   O_DECODE);
      add_vec("ill",   6'b111111, 6'd0,     1'b0, 1'b0, StFetch,    O_FETCH_WAIT);

      // Reset: enables forced low even with mem_ready high in FETCH
      rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      #1;
      check("reset_state", state_o, StFetch);
      tick();
      tick();
      check("reset_outs", outs, O_FETCH_WAIT);
      check("reset_hold_state", state_o, StFetch);
      rst = 1'b0;

      foreach (vecs[i]) begin
         op = vecs[i].op; funct = vecs[i].funct;
         zero = vecs[i].zero; mem_ready = vecs[i].mem_ready;
         #1;
         check({vecs[i].name, "_state"}, state_o, vecs[i].st);
         check({vecs[i].name, "_outs"}, outs, vecs[i].outs);
         tick();
      end

      // sw stalled in MEMWR, then reset asynchronously mid-cycle
      op = OP_SW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1;
      check("sw_stall_state", state_o, StMemWr);
      check("sw_stall_memwrite", memwrite, 1'b1);
      tick();
      #2;
      check("sw_stall2_memwrite", memwrite, 1'b1);
      mem_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_async_state", state_o, StFetch);
      check("rst_async_memwrite", memwrite, 1'b0);
      check("rst_async_pc_en", pc_en, 1'b0);
      check("rst_async_irwrite", irwrite, 1'b0);
      tick();
      check("rst_held_state", state_o, StFetch);
      check("rst_held_memwrite", memwrite, 1'b0);
      rst = 1'b0;
      #1;
      check("post_rst_state", state_o, StFetch);
      check("post_rst_outs", outs, O_FETCH_RDY);
      tick();
      check("post_rst_decode", state_o, StDecode);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
